// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for 640x480@60 Hz VGA, clocked by the PLL pixel
//   clock. Timing is held idle until the PLL reports lock and restarts from
//   position (0,0) every time lock is (re)acquired; a partial frame is never
//   resumed.
//
// Ports
//   clk         in   pixel clock (PLL outclk_0)
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL lock flag, asynchronous to clk
//   hsync       out  horizontal sync, asserted level = SYNC_POL
//   vsync       out  vertical sync, asserted level = SYNC_POL
//   de          out  data enable, high inside the visible region
//   x           out  current horizontal position, 0..H_TOTAL-1
//   y           out  current vertical position, 0..V_TOTAL-1
//   line_start  out  one-cycle pulse at x==0 of every line
//   frame_start out  one-cycle pulse at x==0,y==0
//
// All outputs are registers. H_TOTAL and V_TOTAL must not exceed 1024 since
// the position counters are 10 bits wide.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DE_END     = 10'(H_ACTIVE);
  localparam logic [9:0] V_DE_END     = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  typedef enum logic {IDLE, RUN} state_t;

  // -------------------------------------------------------------------------
  // Two-flop lock synchroniser; lock_s is the only lock value the FSM uses.
  // -------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       lock_s;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          if (gi == 0) sync_reg[gi] <= pll_locked;
          else         sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign lock_s = sync_reg[1];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  state_t state_reg, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next position and registered outputs. h_reg/v_reg hold the position the
  // outputs currently describe, so all decodes are taken from h_next/v_next
  // and land in the same register stage as the position itself.
  // -------------------------------------------------------------------------
  logic [9:0] h_reg, v_reg, h_next, v_next;
  logic       de_reg, hsync_reg, vsync_reg, line_start_reg, frame_start_reg;
  logic       de_next, hsync_next, vsync_next, line_start_next, frame_start_next;

  always_comb begin
    state_next       = state_reg;
    h_next           = 10'd0;
    v_next           = 10'd0;
    de_next          = 1'b0;
    hsync_next       = SYNC_OFF;
    vsync_next       = SYNC_OFF;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Entering RUN always starts at (0,0); defaults already say so.
        if (lock_s) state_next = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_next = IDLE;
        end else if (h_reg == H_LAST) begin
          h_next = 10'd0;
          v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
        end else begin
          h_next = h_reg + 10'd1;
          v_next = v_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next == RUN) begin
      de_next          = (h_next < H_DE_END) && (v_next < V_DE_END);
      hsync_next       = ((h_next >= H_SYNC_START) && (h_next < H_SYNC_END)) ? SYNC_ON : SYNC_OFF;
      vsync_next       = ((v_next >= V_SYNC_START) && (v_next < V_SYNC_END)) ? SYNC_ON : SYNC_OFF;
      line_start_next  = (h_next == 10'd0);
      frame_start_next = (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg           <= 10'd0;
      v_reg           <= 10'd0;
      de_reg          <= 1'b0;
      hsync_reg       <= SYNC_OFF;
      vsync_reg       <= SYNC_OFF;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      de_reg          <= de_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign x           = h_reg;
  assign y           = v_reg;
  assign de          = de_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Self-checking bench for vga_timing_gen, run with a reduced raster
//   (32 clocks x 19 lines) so whole frames fit in a short run:
//     H: active 16, fp 4, sync 6, bp 6   -> hsync at h=20..25
//     V: active 12, fp 2, sync 2, bp 3   -> vsync at v=14..15
//   A reference model tracks how many consecutive cycles the synchronised
//   lock has been high and derives the raster position arithmetically.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 19

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       hsync, vsync, de, line_start, frame_start;
  logic [9:0] x, y;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // {x, y, de, hsync, vsync, line_start, frame_start}
  function automatic logic [24:0] pack(int px, int py, bit pde, bit phs, bit pvs, bit pls, bit pfs);
    return {10'(px), 10'(py), pde, phs, pvs, pls, pfs};
  endfunction

  localparam logic [24:0] IDLE_V = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic logic [24:0] dut_vec();
    return {x, y, de, hsync, vsync, line_start, frame_start};
  endfunction

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                  name, act[24:15], act[14:5], act[4], act[3], act[2], act[1], act[0],
                  exp[24:15], exp[14:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // hist holds the last two sampled lock values; the oldest is what the
  // design acts on at the current edge. run counts consecutive running cycles.
  bit hist[$];
  int run = 0;

  initial begin
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  end

  function automatic logic [24:0] model_vec(int r);
    int p, h, v;
    if (r == 0) return IDLE_V;
    p = r - 1;
    h = p % HT;
    v = (p / HT) % VT;
    return pack(h, v, (h < HA) && (v < VA),
                !((h >= HA + HF) && (h < HA + HF + HS)),
                !((v >= VA + VF) && (v < VA + VF + VS)),
                h == 0, (h == 0) && (v == 0));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit seen;
    if (!rst_n) begin
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      run = 0;
    end else begin
      seen = hist.pop_front();
      hist.push_back(pll_locked);
      run = seen ? run + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) chk("model", dut_vec(), model_vec(run));
  end

  // ---------------- directed vectors for the first frame ----------------
  typedef struct {
    int          c;     // cycles since the first (0,0) output
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int idx, n_de, n_hs, n_vs, n_fs, n_ls;

    tbl[0]  = '{0,   pack(0, 0, 1, 1, 1, 1, 1)};
    tbl[1]  = '{15,  pack(15, 0, 1, 1, 1, 0, 0)};
    tbl[2]  = '{16,  pack(16, 0, 0, 1, 1, 0, 0)};
    tbl[3]  = '{19,  pack(19, 0, 0, 1, 1, 0, 0)};
    tbl[4]  = '{20,  pack(20, 0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{25,  pack(25, 0, 0, 0, 1, 0, 0)};
    tbl[6]  = '{26,  pack(26, 0, 0, 1, 1, 0, 0)};
    tbl[7]  = '{31,  pack(31, 0, 0, 1, 1, 0, 0)};
    tbl[8]  = '{32,  pack(0, 1, 1, 1, 1, 1, 0)};
    tbl[9]  = '{384, pack(0, 12, 0, 1, 1, 1, 0)};
    tbl[10] = '{448, pack(0, 14, 0, 1, 0, 1, 0)};
    tbl[11] = '{468, pack(20, 14, 0, 0, 0, 0, 0)};
    tbl[12] = '{511, pack(31, 15, 0, 1, 0, 0, 0)};
    tbl[13] = '{512, pack(0, 16, 0, 1, 1, 1, 0)};
    tbl[14] = '{607, pack(31, 18, 0, 1, 1, 0, 0)};
    tbl[15] = '{608, pack(0, 0, 1, 1, 1, 1, 1)};

    // Reset and idle bring-up
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("idle_unlocked", dut_vec(), IDLE_V);

    // Lock latency: first sampled high at edge k, (0,0) after k+2
    @(negedge clk) pll_locked = 1'b1;
    @(posedge clk); #1 chk("lat_k", dut_vec(), IDLE_V);
    @(posedge clk); #1 chk("lat_k1", dut_vec(), IDLE_V);
    @(posedge clk); #1 chk("lat_k2", dut_vec(), tbl[0].exp);

    // Walk one full frame, comparing table points and counting pulses
    n_de = de; n_hs = !hsync; n_vs = !vsync; n_fs = frame_start; n_ls = line_start;
    idx = 1;
    for (int c = 1; c <= 608; c++) begin
      @(posedge clk); #1;
      if (c < 608) begin
        n_de += de; n_hs += !hsync; n_vs += !vsync;
        n_fs += frame_start; n_ls += line_start;
      end
      if (idx < 16 && tbl[idx].c == c) begin
        chk($sformatf("tbl_c%0d", c), dut_vec(), tbl[idx].exp);
        idx++;
      end
    end
    chk_int("de_cycles", n_de, HA * VA);
    chk_int("hsync_cycles", n_hs, HS * VT);
    chk_int("vsync_cycles", n_vs, VS * HT);
    chk_int("frame_pulses", n_fs, 1);
    chk_int("line_pulses", n_ls, VT);

    // Lock loss mid-frame at (10,5), then relock
    repeat (5 * HT + 10) @(posedge clk);
    #1 chk("pre_loss", dut_vec(), pack(10, 5, 1, 1, 1, 0, 0));
    @(negedge clk) pll_locked = 1'b0;
    @(posedge clk); #1 chk("loss_m", dut_vec(), pack(11, 5, 1, 1, 1, 0, 0));
    @(posedge clk); #1 chk("loss_m1", dut_vec(), pack(12, 5, 1, 1, 1, 0, 0));
    @(posedge clk); #1 chk("loss_m2", dut_vec(), IDLE_V);
    repeat (10) @(posedge clk);
    @(negedge clk) pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("relock", dut_vec(), pack(0, 0, 1, 1, 1, 1, 1));

    // Asynchronous reset between edges at (28,3)
    repeat (3 * HT + 28) @(posedge clk);
    #1 chk("pre_arst", dut_vec(), pack(28, 3, 0, 1, 1, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk("arst_immediate", dut_vec(), IDLE_V);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 chk("arst_e1", dut_vec(), IDLE_V);
    @(posedge clk); #1 chk("arst_e2", dut_vec(), IDLE_V);
    @(posedge clk); #1 chk("arst_restart", dut_vec(), pack(0, 0, 1, 1, 1, 1, 1));

    // Random lock toggling and occasional async resets, checked by the model
    for (int i = 0; i < 40; i++) begin
      @(negedge clk) pll_locked = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 1200)) @(posedge clk);
      if ($urandom_range(0, 7) == 0) begin
        #3 rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
      end
    end
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
